iter_mul_unit: RTL

ITER_MUL_UNIT -- requirements
Module: iter_mul_unit

---
 rtl/iter_mul_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/iter_mul_unit.sv
// Iterative shift-add multiplier for MUL / MLA / UMULL / SMULL.
// Retires BITS_PER_CYCLE multiplier bits per cycle; {N,Z,C,V} are registered with the result.
module iter_mul_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags
);
  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N);
  localparam logic [1:0] MODE_MLA   = 2'b01;
  localparam logic [1:0] MODE_SMULL = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
  state_t state_q, state_d;

  logic [1:0]         mode_q;
  logic [WIDTH-1:0]   a_q, b_q, acc_q, mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic               sign_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   res_lo_q, res_hi_q;
  logic [3:0]         flags_q;

  logic                            accept, is_signed;
  logic [BITS_PER_CYCLE-1:0]       chunk;
  logic [WIDTH+BITS_PER_CYCLE-1:0] partial;
  logic [2*WIDTH-1:0]              prod_step, prod_fix;
  logic [WIDTH-1:0]                fix_lo, fix_hi;
  logic                            fix_n, fix_z;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign is_signed = (mode_q == MODE_SMULL);

  // Low half of prod_q holds the unretired multiplier bits; partial sums enter the high half.
  always_comb begin
    chunk     = prod_q[BITS_PER_CYCLE-1:0];
    partial   = {{BITS_PER_CYCLE{1'b0}}, prod_q[2*WIDTH-1:WIDTH]}
              + ({{BITS_PER_CYCLE{1'b0}}, mcand_q} * {{WIDTH{1'b0}}, chunk});
    prod_step = {partial, prod_q[WIDTH-1:BITS_PER_CYCLE]};
  end

  always_comb begin
    prod_fix = apply_sign(prod_q, sign_q);
    fix_lo   = prod_fix[WIDTH-1:0] + ((mode_q == MODE_MLA) ? acc_q : '0);
    fix_hi   = mode_q[1] ? prod_fix[2*WIDTH-1:WIDTH] : '0;
    fix_n    = mode_q[1] ? fix_hi[WIDTH-1] : fix_lo[WIDTH-1];
    fix_z    = ({fix_hi, fix_lo} == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  if (cnt_q == LAST_CNT) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = start ? S_CALC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_CALC) || (state_q == S_FIX);
    done = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      flags_q  <= '0;
    end else begin
      if (accept) begin
        mode_q <= mode;
        a_q    <= a;
        b_q    <= b;
        acc_q  <= acc;
        cnt_q  <= '0;
      end else if (state_q == S_CALC) begin
        cnt_q <= cnt_q + CNT_W'(1);
        // First CALC cycle converts the latched operands; the next N retire multiplier bits.
        if (cnt_q == '0) begin
          mcand_q <= is_signed ? magnitude(a_q) : a_q;
          prod_q  <= {{WIDTH{1'b0}}, (is_signed ? magnitude(b_q) : b_q)};
          sign_q  <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        end else begin
          prod_q <= prod_step;
        end
      end
      if (state_q == S_FIX) begin
        res_lo_q <= fix_lo;
        res_hi_q <= fix_hi;
        flags_q  <= {fix_n, fix_z, 2'b00};
      end
    end
  end

  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;
  assign flags     = flags_q;

endmodule
